// File: rtl/mmio_store_fifo.sv
// Memory-mapped output FIFO snooping the CPU data-memory write path.
// Stores to IO_DATA_ADDR are queued and drained over valid/ready; IO_STAT_ADDR exposes status.
module mmio_store_fifo #(
  parameter int          DEPTH        = 4,
  parameter int          PTR_W        = 2,
  parameter logic [31:0] IO_DATA_ADDR = 32'h0000_00F8,
  parameter logic [31:0] IO_STAT_ADDR = 32'h0000_00FC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] stat_rdata,
  output logic        io_hit,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        full,
  output logic        ovf
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;

  logic push_req;
  logic clr_req;
  logic pop;
  logic push_ok;

  assign io_hit    = (mem_addr == IO_DATA_ADDR) || (mem_addr == IO_STAT_ADDR);
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign full      = (count_q == CNT_FULL);
  assign ovf       = ovf_q;

  always_comb begin
    stat_rdata      = '0;
    stat_rdata[4:0] = 5'(count_q);
    stat_rdata[6]   = full;
    stat_rdata[7]   = ovf_q;
  end

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    push_req = mem_wr && (mem_addr == IO_DATA_ADDR);
    clr_req  = mem_wr && (mem_addr == IO_STAT_ADDR);
    pop      = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push_ok  = push_req && (!full || pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = mem_wdata;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Clear first so a coincident drop takes priority.
    if (clr_req) begin
      ovf_d = 1'b0;
    end
    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: storage is reset here because out_data exposes the head entry even when empty.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mmio_store_fifo.sv
// Scoreboard bench for mmio_store_fifo: accepted stores are queued as expected output,
// a negedge monitor compares every handshake; status and decode are checked directly.
module tb_mmio_store_fifo;

  logic        clk;
  logic        rst;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] stat_rdata;
  logic        io_hit;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        full;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  localparam logic [31:0] A_DATA = 32'h0000_00F8;
  localparam logic [31:0] A_STAT = 32'h0000_00FC;

  mmio_store_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .stat_rdata (stat_rdata),
    .io_hit     (io_hit),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .full       (full),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head word must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %08h expected no output", out_data);
      end else begin
        check("sb_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_wr    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
  endtask

  // One write cycle; the caller decides whether the word is expected to be accepted.
  task automatic store(input logic [31:0] addr, input logic [31:0] data, input bit accepted);
    mem_wr    = 1'b1;
    mem_addr  = addr;
    mem_wdata = data;
    if (accepted) exp_q.push_back(data);
    cycle();
    idle();
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) cycle();
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    out_ready = 1'b0;
    idle();

    // 1. reset then idle
    repeat (2) cycle();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", out_data, 32'h0);
    rst = 1'b1;
    cycle();
    check("idle_valid", 32'(out_valid), 32'h0);
    check("idle_full", 32'(full), 32'h0);
    check("idle_ovf", 32'(ovf), 32'h0);
    check("idle_stat", stat_rdata, 32'h0);

    // 2. single store then pop
    store(A_DATA, 32'hDEAD_BEEF, 1'b1);
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_data", out_data, 32'hDEAD_BEEF);
    check("single_stat", stat_rdata, 32'h1);
    drain(1);
    check("single_empty", 32'(out_valid), 32'h0);
    check("single_stat0", stat_rdata, 32'h0);

    // 3. fill and overflow
    for (int i = 1; i <= 4; i++) store(A_DATA, 32'(i), 1'b1);
    check("fill_full", 32'(full), 32'h1);
    check("fill_stat", stat_rdata, 32'h44);
    check("fill_head", out_data, 32'h1);
    store(A_DATA, 32'h5, 1'b0);
    check("ovf_flag", 32'(ovf), 32'h1);
    check("ovf_stat", stat_rdata, 32'hC4);
    check("ovf_head", out_data, 32'h1);

    // 4. push while full with a same-cycle pop
    out_ready = 1'b1;
    store(A_DATA, 32'h9, 1'b1);
    out_ready = 1'b0;
    check("pp_stat", stat_rdata, 32'hC4);
    check("pp_head", out_data, 32'h2);
    drain(4);
    check("pp_drained", stat_rdata, 32'h80);

    // 5. overflow clear and address decode
    store(A_STAT, 32'h1234_5678, 1'b0);
    check("clr_ovf", 32'(ovf), 32'h0);
    check("clr_stat", stat_rdata, 32'h0);
    mem_wr = 1'b1; mem_addr = 32'h0000_00F4; mem_wdata = 32'hBAD0_0000;
    #1 check("dec_f4_hit", 32'(io_hit), 32'h0);
    cycle();
    idle();
    check("dec_f4_nopush", stat_rdata, 32'h0);
    mem_addr = A_DATA;
    #1 check("dec_f8_hit", 32'(io_hit), 32'h1);
    mem_addr = A_STAT;
    #1 check("dec_fc_hit", 32'(io_hit), 32'h1);
    mem_addr = 32'h1000_00F8;
    #1 check("dec_hi_hit", 32'(io_hit), 32'h0);
    idle();

    // pointer wrap: 3 rounds of fill, push-while-full-with-pop, drain
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) store(A_DATA, 32'hA000_0000 + 32'(r * 16 + i), 1'b1);
      out_ready = 1'b1;
      store(A_DATA, 32'hB000_0000 + 32'(r), 1'b1);
      out_ready = 1'b0;
      check("wrap_full", stat_rdata, 32'h44);
      drain(4);
      check("wrap_empty", stat_rdata, 32'h0);
    end

    // 6. async reset mid-stream
    for (int i = 0; i < 4; i++) store(A_DATA, 32'hC000_0000 + 32'(i), 1'b1);
    store(A_DATA, 32'hEEEE_EEEE, 1'b0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    cycle();
    out_ready = 1'b1;
    check("pre_rst_stat", stat_rdata, 32'h83);
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_ovf", 32'(ovf), 32'h0);
    check("arst_stat", stat_rdata, 32'h0);
    check("arst_data", out_data, 32'h0);
    out_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    store(A_DATA, 32'hA5A5_5A5A, 1'b1);
    check("post_rst_head", out_data, 32'hA5A5_5A5A);
    check("post_rst_stat", stat_rdata, 32'h1);
    drain(1);

    check("sb_all_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
